// File: rtl/instr_encoder.sv
// Streaming RV32I assembler: scatters a signed immediate into I/S/B/U/J slots and splits wide li-style ADDI into LUI+ADDI.
// Build option: define ENCODER_RANGE_CHECK_EN to flag out-of-range/misaligned immediates and unsupported opcodes on o_err.
module instr_encoder #(
   parameter int INST_SIZE = 32,
   parameter int DATA_SIZE = 32
) (
   input  logic                        i_clk,
   input  logic                        i_rst_n,
   input  logic                        i_in_valid,
   output logic                        o_in_ready,
   input  logic [6:0]                  i_op,
   input  logic [4:0]                  i_rd,
   input  logic [4:0]                  i_rs1,
   input  logic [4:0]                  i_rs2,
   input  logic [2:0]                  i_funct3,
   input  logic [6:0]                  i_funct7,
   input  logic signed [DATA_SIZE-1:0] i_immediate,
   output logic                        o_out_valid,
   input  logic                        i_out_ready,
   output logic [INST_SIZE-1:0]        o_instr,
   output logic                        o_last,
   output logic                        o_err
);

   // state | meaning
   // EMPTY | no word on the output, ready for a request
   // ONE   | single (or final ADDI) word presented, may reload on handshake
   // LUI   | LUI half of a pair presented, ADDI waiting in pend_q

   localparam logic [6:0] OP_LOADS    = 7'b0000011;
   localparam logic [6:0] OP_STORES   = 7'b0100011;
   localparam logic [6:0] OP_ALC_I    = 7'b0010011;
   localparam logic [6:0] OP_BRANCHES = 7'b1100011;
   localparam logic [6:0] OP_LUI      = 7'b0110111;
   localparam logic [6:0] OP_AUIPC    = 7'b0010111;
   localparam logic [6:0] OP_JAL      = 7'b1101111;
   localparam logic [6:0] OP_JALR     = 7'b1100111;
   localparam logic [INST_SIZE-1:0] NOP_WORD = 32'h0000_0013;

`ifdef ENCODER_RANGE_CHECK_EN
   localparam logic RANGE_CHECK = 1'b1;
`else
   localparam logic RANGE_CHECK = 1'b0;
`endif

   typedef enum logic [1:0] {
      ST_EMPTY = 2'd0,
      ST_ONE   = 2'd1,
      ST_LUI   = 2'd2
   } state_t;

   state_t                 state_q, state_d;
   logic                   out_valid_q, out_valid_d;
   logic [INST_SIZE-1:0]   instr_q, instr_d;
   logic                   last_q, last_d;
   logic                   err_q, err_d;
   logic [INST_SIZE-1:0]   pend_q, pend_d;

   logic [31:0]            imm;
   logic                   fit12, fit13, fit21;
   logic [19:0]            lui_hi;
   logic [INST_SIZE-1:0]   enc_word;
   logic [INST_SIZE-1:0]   enc_addi;
   logic                   enc_expand;
   logic                   enc_bad;
   logic                   enc_err;
   logic                   in_ready;
   logic                   accept;
   logic                   handshake;

   assign imm   = i_immediate;
   assign fit12 = (&imm[31:11]) | ~(|imm[31:11]);
   assign fit13 = (&imm[31:12]) | ~(|imm[31:12]);
   assign fit21 = (&imm[31:20]) | ~(|imm[31:20]);
   // (imm + 0x800) >> 12 without a 32-bit adder: round the upper part by imm[11]
   assign lui_hi = imm[31:12] + {19'd0, imm[11]};

   always_comb begin
      enc_word   = NOP_WORD;
      enc_expand = 1'b0;
      enc_bad    = 1'b0;
      enc_addi   = {imm[11:0], i_rd, 3'b000, i_rd, OP_ALC_I};
      case (i_op)
         OP_LOADS, OP_JALR: begin
            enc_word = {imm[11:0], i_rs1, i_funct3, i_rd, i_op};
            enc_bad  = ~fit12;
         end
         OP_ALC_I: begin
            if (i_funct3 == 3'b001 || i_funct3 == 3'b101)
               enc_word = {i_funct7, imm[4:0], i_rs1, i_funct3, i_rd, i_op};
            else
               enc_word = {imm[11:0], i_rs1, i_funct3, i_rd, i_op};
            enc_expand = (i_funct3 == 3'b000) && (i_rs1 == 5'd0) && !fit12;
            enc_bad    = ~fit12 & ~enc_expand;
            if (enc_expand)
               enc_word = {lui_hi, i_rd, OP_LUI};
         end
         OP_STORES: begin
            enc_word = {imm[11:5], i_rs2, i_rs1, i_funct3, imm[4:0], i_op};
            enc_bad  = ~fit12;
         end
         OP_BRANCHES: begin
            enc_word = {imm[12], imm[10:5], i_rs2, i_rs1, i_funct3, imm[4:1], imm[11], i_op};
            enc_bad  = ~fit13 | imm[0];
         end
         OP_LUI, OP_AUIPC: begin
            enc_word = {imm[31:12], i_rd, i_op};
            enc_bad  = |imm[11:0];
         end
         OP_JAL: begin
            enc_word = {imm[20], imm[10:1], imm[11], imm[19:12], i_rd, i_op};
            enc_bad  = ~fit21 | imm[0];
         end
         default: begin
            enc_word = NOP_WORD;
            enc_bad  = 1'b1;
         end
      endcase
      enc_err = RANGE_CHECK & enc_bad;
   end

   always_comb begin
      case (state_q)
         ST_EMPTY: in_ready = 1'b1;
         ST_ONE:   in_ready = i_out_ready;
         default:  in_ready = 1'b0;
      endcase
   end

   assign accept    = i_in_valid & in_ready;
   assign handshake = out_valid_q & i_out_ready;

   always_comb begin
      state_d     = state_q;
      out_valid_d = out_valid_q;
      instr_d     = instr_q;
      last_d      = last_q;
      err_d       = err_q;
      pend_d      = pend_q;
      case (state_q)
         ST_EMPTY, ST_ONE: begin
            if (accept) begin
               out_valid_d = 1'b1;
               instr_d     = enc_word;
               last_d      = ~enc_expand;
               err_d       = enc_expand ? 1'b0 : enc_err;
               pend_d      = enc_addi;
               state_d     = enc_expand ? ST_LUI : ST_ONE;
            end else if (handshake) begin
               out_valid_d = 1'b0;
               state_d     = ST_EMPTY;
            end
         end
         ST_LUI: begin
            if (handshake) begin
               instr_d = pend_q;
               last_d  = 1'b1;
               err_d   = 1'b0;
               state_d = ST_ONE;
            end
         end
         default: begin
            out_valid_d = 1'b0;
            state_d     = ST_EMPTY;
         end
      endcase
   end

   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         state_q     <= ST_EMPTY;
         out_valid_q <= 1'b0;
         instr_q     <= '0;
         last_q      <= 1'b0;
         err_q       <= 1'b0;
         pend_q      <= '0;
      end else begin
         state_q     <= state_d;
         out_valid_q <= out_valid_d;
         instr_q     <= instr_d;
         last_q      <= last_d;
         err_q       <= err_d;
         pend_q      <= pend_d;
      end
   end

   assign o_in_ready  = in_ready;
   assign o_out_valid = out_valid_q;
   assign o_instr     = instr_q;
   assign o_last      = last_q;
   assign o_err       = err_q;

endmodule

// File: tb/tb_instr_encoder.sv
// Randomized bench for instr_encoder against an arithmetic reference model and word scoreboard.
// Honours ENCODER_RANGE_CHECK_EN so the same bench covers both builds.
module tb_instr_encoder;

   logic               clk = 1'b0;
   logic               rst_n;
   logic               in_valid;
   logic               in_ready;
   logic [6:0]         op;
   logic [4:0]         rd, rs1, rs2;
   logic [2:0]         f3;
   logic [6:0]         f7;
   logic signed [31:0] imm;
   logic               out_valid;
   logic               out_ready;
   logic [31:0]        instr;
   logic               last;
   logic               err;

`ifdef ENCODER_RANGE_CHECK_EN
   localparam bit RC = 1'b1;
`else
   localparam bit RC = 1'b0;
`endif

   localparam logic [6:0] LOADS = 7'h03, STORES = 7'h23, ALC = 7'h13, BR = 7'h63;
   localparam logic [6:0] LUI = 7'h37, AUIPC = 7'h17, JAL = 7'h6F, JALR = 7'h67;

   instr_encoder dut (
      .i_clk       (clk),
      .i_rst_n     (rst_n),
      .i_in_valid  (in_valid),
      .o_in_ready  (in_ready),
      .i_op        (op),
      .i_rd        (rd),
      .i_rs1       (rs1),
      .i_rs2       (rs2),
      .i_funct3    (f3),
      .i_funct7    (f7),
      .i_immediate (imm),
      .o_out_valid (out_valid),
      .i_out_ready (out_ready),
      .o_instr     (instr),
      .o_last      (last),
      .o_err       (err)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] w;
      logic        last;
      logic        err;
   } exp_t;

   exp_t        sb[$];
   int          n_cmp = 0;
   int          n_bad = 0;
   logic [31:0] obs_instr;
   logic        obs_last, obs_err, obs_ready, obs_valid;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   function automatic bit fits(input longint v, input int n);
      longint lim;
      lim = longint'(1) <<< (n - 1);
      return (v >= -lim) && (v < lim);
   endfunction

   task automatic push(input logic [31:0] w, input logic l, input logic e);
      exp_t x;
      x.w = w; x.last = l; x.err = e;
      sb.push_back(x);
   endtask

   // Reference: fields placed by shift-and-add from the instruction format tables.
   task automatic model(input bit [31:0] o, input bit [31:0] d, input bit [31:0] r1,
                        input bit [31:0] r2, input bit [31:0] fn3, input bit [31:0] fn7,
                        input int p_imm);
      longint    s;
      bit [31:0] u, base, w, hi;
      bit        bad;
      s    = p_imm;
      u    = p_imm;
      base = o + (d << 7) + (fn3 << 12) + (r1 << 15);
      bad  = 1'b0;
      if (o == ALC && fn3 == 0 && r1 == 0 && !fits(s, 12)) begin
         hi = 32'((s + 2048) >>> 12) & 32'hFFFFF;
         push((hi << 12) + (d << 7) + LUI, 1'b0, 1'b0);
         push(((u & 32'hFFF) << 20) + (d << 15) + (d << 7) + ALC, 1'b1, 1'b0);
         return;
      end
      case (o)
         LOADS, JALR: begin
            w = base + ((u & 32'hFFF) << 20);
            bad = !fits(s, 12);
         end
         ALC: begin
            if (fn3 == 1 || fn3 == 5) w = base + ((u & 31) << 20) + (fn7 << 25);
            else                      w = base + ((u & 32'hFFF) << 20);
            bad = !fits(s, 12);
         end
         STORES: begin
            w = o + (fn3 << 12) + (r1 << 15) + (r2 << 20) + ((u & 31) << 7) + (((u >> 5) & 127) << 25);
            bad = !fits(s, 12);
         end
         BR: begin
            w = o + (fn3 << 12) + (r1 << 15) + (r2 << 20) + (((u >> 12) & 1) << 31)
              + (((u >> 5) & 63) << 25) + (((u >> 1) & 15) << 8) + (((u >> 11) & 1) << 7);
            bad = !fits(s, 13) || (u & 1) != 0;
         end
         LUI, AUIPC: begin
            w = (u & 32'hFFFFF000) + (d << 7) + o;
            bad = (u & 32'hFFF) != 0;
         end
         JAL: begin
            w = o + (d << 7) + (((u >> 20) & 1) << 31) + (((u >> 1) & 1023) << 21)
              + (((u >> 11) & 1) << 20) + (((u >> 12) & 255) << 12);
            bad = !fits(s, 21) || (u & 1) != 0;
         end
         default: begin
            w = 32'h13;
            bad = 1'b1;
         end
      endcase
      push(w, 1'b1, RC & bad);
   endtask

   task automatic step(input bit v, input bit rdy, input logic [6:0] p_op, input logic [4:0] p_rd,
                       input logic [4:0] p_rs1, input logic [4:0] p_rs2, input logic [2:0] p_f3,
                       input logic [6:0] p_f7, input int p_imm);
      @(negedge clk);
      in_valid = v; out_ready = rdy; op = p_op; rd = p_rd; rs1 = p_rs1; rs2 = p_rs2;
      f3 = p_f3; f7 = p_f7; imm = p_imm;
      #1;
      obs_instr = instr; obs_last = last; obs_err = err; obs_ready = in_ready; obs_valid = out_valid;
      chk("out_valid", out_valid, sb.size() != 0);
      chk("in_ready", in_ready, (sb.size() == 0) || (sb.size() == 1 && rdy));
      if (out_valid && sb.size() != 0) begin
         chk("instr", instr, sb[0].w);
         chk("last", last, sb[0].last);
         chk("err", err, sb[0].err);
         if (rdy) void'(sb.pop_front());
      end
      if (v && in_ready) model(p_op, p_rd, p_rs1, p_rs2, p_f3, p_f7, p_imm);
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
      repeat (2) @(negedge clk);
      #1;
      sb.delete();
      chk("rst_valid", out_valid, 0);
      chk("rst_instr", instr, 0);
      chk("rst_last", last, 0);
      chk("rst_err", err, 0);
      rst_n = 1'b1;
   endtask

   initial begin
      logic [6:0] ops[10];
      int         edges[11];
      int         kind, r_imm;
      logic [6:0] r_op;
      logic [4:0] r_rs1;
      logic [2:0] r_f3;
      ops   = '{LOADS, STORES, ALC, BR, LUI, AUIPC, JAL, JALR, 7'h33, 7'h0F};
      edges = '{-2048, 2047, -2049, 2048, 4095, -4096, 4094, -4095, 1048575, -1048576, 1048576};
      rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
      op = '0; rd = '0; rs1 = '0; rs2 = '0; f3 = '0; f7 = '0; imm = '0;
      do_reset();

      step(1, 1, ALC, 5, 0, 0, 0, 0, -1);
      step(0, 1, 0, 0, 0, 0, 0, 0, 0);
      chk("addi_m1", obs_instr, 32'hFFF00293);
      chk("addi_m1_last", obs_last, 1);

      step(1, 1, ALC, 1, 0, 0, 0, 0, 32'h12345FFF);
      step(0, 1, 0, 0, 0, 0, 0, 0, 0);
      chk("li_lui", obs_instr, 32'h123460B7);
      chk("li_lui_last", obs_last, 0);
      chk("li_lui_ready", obs_ready, 0);
      step(0, 1, 0, 0, 0, 0, 0, 0, 0);
      chk("li_addi", obs_instr, 32'hFFF08093);
      chk("li_addi_last", obs_last, 1);

      step(1, 1, BR, 0, 1, 2, 0, 0, 8);
      step(1, 1, JAL, 1, 0, 0, 0, 0, 2048);
      chk("beq8", obs_instr, 32'h00208463);
      step(0, 1, 0, 0, 0, 0, 0, 0, 0);
      chk("jal2048", obs_instr, 32'h001000EF);

      step(1, 1, JAL, 1, 0, 0, 0, 0, 3);
      step(0, 1, 0, 0, 0, 0, 0, 0, 0);
      chk("jal3_word", obs_instr, 32'h002000EF);
      chk("jal3_err", obs_err, RC);

      step(1, 1, BR, 0, 1, 2, 0, 0, 8);
      repeat (3) begin
         step(1, 0, JAL, 1, 0, 0, 0, 0, 2048);
         chk("hold_word", obs_instr, 32'h00208463);
         chk("hold_ready", obs_ready, 0);
      end
      step(1, 1, JAL, 1, 0, 0, 0, 0, 2048);
      chk("release_ready", obs_ready, 1);
      step(0, 1, 0, 0, 0, 0, 0, 0, 0);
      chk("after_hold", obs_instr, 32'h001000EF);

      step(1, 0, ALC, 1, 0, 0, 0, 0, 32'h12345FFF);
      step(0, 0, 0, 0, 0, 0, 0, 0, 0);
      chk("mid_lui_last", obs_last, 0);
      do_reset();
      repeat (3) begin
         step(0, 1, 0, 0, 0, 0, 0, 0, 0);
         chk("no_addi", obs_valid, 0);
      end

      for (int i = 0; i < 800; i++) begin
         r_op  = ops[$urandom_range(0, 9)];
         r_f3  = 3'($urandom);
         r_rs1 = 5'($urandom);
         kind  = $urandom_range(0, 5);
         case (kind)
            0:       r_imm = int'($urandom_range(0, 4095)) - 2048;
            1:       r_imm = edges[$urandom_range(0, 10)];
            2:       r_imm = int'($urandom);
            3:       r_imm = (int'($urandom_range(0, 8191)) - 4096) & ~1;
            4:       r_imm = int'($urandom & 32'hFFFF_F000);
            default: r_imm = int'($urandom_range(0, 2097151)) - 1048576;
         endcase
         if (r_op == ALC && $urandom_range(0, 1) == 1) begin
            r_f3 = 3'd0; r_rs1 = 5'd0;
         end
         step($urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0, r_op, 5'($urandom),
              r_rs1, 5'($urandom), r_f3, 7'($urandom), r_imm);
      end

      for (int i = 0; i < 10 && sb.size() != 0; i++)
         step(0, 1, 0, 0, 0, 0, 0, 0, 0);
      chk("drained", sb.size(), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
